// File: rtl/multich_peak_reporter.sv
`default_nettype none
// ============================================================================
//  Module      : multich_peak_reporter
//  Description : Per-channel, per-frame peak tracker with threshold-crossing
//                counters. When every channel has finished its frame, or a
//                timeout expires, it emits one multi-beat AXI-Stream report.
//                Channel results that arrive while their slot is still
//                occupied are dropped and counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module multich_peak_reporter #(
    parameter int NUM_CH        = 2,
    parameter int DATA_LEN      = 64,
    parameter int IDX_LEN       = 32,
    parameter int FRAME_TIMEOUT = 16384
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [NUM_CH*DATA_LEN-1:0]   s_mag_tdata,
    input  logic [NUM_CH-1:0]            s_mag_tvalid,
    input  logic [NUM_CH-1:0]            s_mag_tlast,
    input  logic [NUM_CH*IDX_LEN-1:0]    s_mag_index,
    input  logic                         frame_start,
    input  logic [31:0]                  frame_id,
    input  logic [IDX_LEN-1:0]           cutoff,
    input  logic [NUM_CH*DATA_LEN-1:0]   threshold,
    output logic [63:0]                  m_axis_tdata,
    output logic                         m_axis_tvalid,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    output logic [15:0]                  drop_count,
    output logic                         busy
);

    localparam int              NBEATS    = 1 + 2 * NUM_CH;
    localparam int              BW        = 5;
    localparam logic [BW-1:0]   LAST_BEAT = BW'(NBEATS - 1);
    localparam logic [31:0]     TMO_LAST  = 32'(FRAME_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    // Frame configuration
    logic [IDX_LEN-1:0]                 cutoff_q;
    logic [NUM_CH-1:0][DATA_LEN-1:0]    thr_q;
    logic [31:0]                        fid_work_q;
    logic [31:0]                        fid_rep_q;

    // Running accumulators
    logic [NUM_CH-1:0][DATA_LEN-1:0]    acc_val_q, acc_val_d;
    logic [NUM_CH-1:0][IDX_LEN-1:0]     acc_idx_q, acc_idx_d;
    logic [NUM_CH-1:0][31:0]            acc_pk_q,  acc_pk_d;
    logic [NUM_CH-1:0]                  acc_above_q, acc_above_d;

    // Latched per-channel results
    logic [NUM_CH-1:0][DATA_LEN-1:0]    res_val_q;
    logic [NUM_CH-1:0][IDX_LEN-1:0]     res_idx_q;
    logic [NUM_CH-1:0][31:0]            res_pk_q;
    logic [NUM_CH-1:0]                  done_mask_q;

    // Report FSM and output registers
    state_t                             state_q;
    logic [31:0]                        timer_q;
    logic [BW-1:0]                      beat_q;
    logic [63:0]                        tdata_q;
    logic                               tvalid_q;
    logic                               tlast_q;
    logic [15:0]                        drop_q;

    // Combinational helpers
    logic [NUM_CH-1:0][DATA_LEN-1:0]    w_data;
    logic [NUM_CH-1:0][IDX_LEN-1:0]     w_index;
    logic [NUM_CH-1:0][DATA_LEN-1:0]    w_thr;
    logic [NUM_CH-1:0]                  w_qual;
    logic [NUM_CH-1:0][DATA_LEN-1:0]    w_upd_val;
    logic [NUM_CH-1:0][IDX_LEN-1:0]     w_upd_idx;
    logic [NUM_CH-1:0][31:0]            w_upd_pk;
    logic [NUM_CH-1:0]                  w_upd_above;
    logic [NUM_CH-1:0]                  w_eof;
    logic [NUM_CH-1:0]                  w_latch;
    logic [NUM_CH-1:0]                  w_drop;
    logic [NUM_CH-1:0]                  w_mask_next;
    logic [IDX_LEN-1:0]                 w_cut;
    logic [31:0]                        w_fid;
    logic [3:0]                         w_drop_n;
    logic [16:0]                        w_drop_sum;
    logic [15:0]                        w_drop_next;
    logic [BW-1:0]                      w_sel;
    logic [63:0]                        w_beat;
    logic                               w_beat_last;

    // A frame_start beat is judged against the incoming configuration
    assign w_cut       = frame_start ? cutoff   : cutoff_q;
    assign w_fid       = frame_start ? frame_id : fid_work_q;
    assign w_mask_next = done_mask_q | w_latch;

    // Per-channel qualification, peak/crossing update and slot arbitration
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_data[c]      = s_mag_tdata[c*DATA_LEN +: DATA_LEN];
            w_index[c]     = s_mag_index[c*IDX_LEN +: IDX_LEN];
            w_thr[c]       = frame_start ? threshold[c*DATA_LEN +: DATA_LEN] : thr_q[c];
            w_qual[c]      = (w_index[c] < w_cut) && (w_data[c] > w_thr[c]);
            w_upd_val[c]   = frame_start ? '0   : acc_val_q[c];
            w_upd_idx[c]   = frame_start ? '0   : acc_idx_q[c];
            w_upd_pk[c]    = frame_start ? '0   : acc_pk_q[c];
            w_upd_above[c] = frame_start ? 1'b0 : acc_above_q[c];
            if (s_mag_tvalid[c]) begin
                if (w_qual[c] && (w_data[c] > w_upd_val[c])) begin
                    w_upd_val[c] = w_data[c];
                    w_upd_idx[c] = w_index[c];
                end
                if (w_qual[c] && !w_upd_above[c] && (w_upd_pk[c] != 32'hFFFF_FFFF)) begin
                    w_upd_pk[c] = w_upd_pk[c] + 32'd1;
                end
                w_upd_above[c] = w_qual[c];
            end
            w_eof[c]       = s_mag_tvalid[c] && s_mag_tlast[c];
            acc_val_d[c]   = w_eof[c] ? '0   : w_upd_val[c];
            acc_idx_d[c]   = w_eof[c] ? '0   : w_upd_idx[c];
            acc_pk_d[c]    = w_eof[c] ? '0   : w_upd_pk[c];
            acc_above_d[c] = w_eof[c] ? 1'b0 : w_upd_above[c];
            w_latch[c]     = w_eof[c] && (state_q != ST_SEND) && !done_mask_q[c];
            w_drop[c]      = w_eof[c] && !((state_q != ST_SEND) && !done_mask_q[c]);
        end
    end

    // Saturating add of this cycle's dropped results
    always_comb begin
        w_drop_n = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_drop_n = w_drop_n + 4'(w_drop[c]);
        end
        w_drop_sum  = {1'b0, drop_q} + 17'(w_drop_n);
        w_drop_next = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end

    // Report beat selection: next beat to present on the output register
    always_comb begin
        w_sel       = tvalid_q ? BW'(beat_q + 1'b1) : beat_q;
        w_beat_last = (w_sel == LAST_BEAT);
        w_beat      = '0;
        if (w_sel == '0) begin
            w_beat = {16'h504B, 8'(NUM_CH), 8'(done_mask_q), fid_rep_q};
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (done_mask_q[c]) begin
                if (w_sel == BW'(1 + 2 * c)) begin
                    w_beat = {32'(res_idx_q[c]), res_pk_q[c]};
                end
                if (w_sel == BW'(2 + 2 * c)) begin
                    w_beat = 64'(res_val_q[c]);
                end
            end
        end
    end

    // Configuration, accumulators, result slots and drop counter
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cutoff_q    <= '0;
            thr_q       <= '0;
            fid_work_q  <= '0;
            acc_val_q   <= '0;
            acc_idx_q   <= '0;
            acc_pk_q    <= '0;
            acc_above_q <= '0;
            res_val_q   <= '0;
            res_idx_q   <= '0;
            res_pk_q    <= '0;
            drop_q      <= '0;
        end else begin
            if (frame_start) begin
                cutoff_q   <= cutoff;
                thr_q      <= threshold;
                fid_work_q <= frame_id;
            end
            acc_val_q   <= acc_val_d;
            acc_idx_q   <= acc_idx_d;
            acc_pk_q    <= acc_pk_d;
            acc_above_q <= acc_above_d;
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_latch[c]) begin
                    res_val_q[c] <= w_upd_val[c];
                    res_idx_q[c] <= w_upd_idx[c];
                    res_pk_q[c]  <= w_upd_pk[c];
                end
            end
            drop_q <= w_drop_next;
        end
    end

    // Report FSM: collect results, wait for all channels or timeout, stream packet
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            beat_q      <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            done_mask_q <= '0;
            fid_rep_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_mask_q <= w_mask_next;
                    if (|w_latch) begin
                        state_q   <= ST_WAIT;
                        fid_rep_q <= w_fid;
                        timer_q   <= '0;
                    end
                end
                ST_WAIT: begin
                    done_mask_q <= w_mask_next;
                    timer_q     <= timer_q + 32'd1;
                    if ((&w_mask_next) || ((FRAME_TIMEOUT != 0) && (timer_q == TMO_LAST))) begin
                        state_q  <= ST_SEND;
                        beat_q   <= '0;
                        tvalid_q <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (!tvalid_q) begin
                        tvalid_q <= 1'b1;
                        tdata_q  <= w_beat;
                        tlast_q  <= w_beat_last;
                    end else if (m_axis_tready) begin
                        if (tlast_q) begin
                            tvalid_q    <= 1'b0;
                            tlast_q     <= 1'b0;
                            beat_q      <= '0;
                            done_mask_q <= '0;
                            state_q     <= ST_IDLE;
                        end else begin
                            beat_q  <= w_sel;
                            tdata_q <= w_beat;
                            tlast_q <= w_beat_last;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign drop_count    = drop_q;
    assign busy          = (state_q != ST_IDLE);

endmodule
`default_nettype wire
